// File: rtl/load_store_unit_pkg.sv
// Shared types, byte-enable constants and opcode helpers for the load/store unit.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } load_store_func_code;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  function automatic logic is_store(input load_store_func_code op);
    case (op)
      SB, SH, SW: is_store = 1'b1;
      default:    is_store = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input load_store_func_code op, input logic [1:0] lo);
    case (op)
      LH, LHU, SH: is_misaligned = lo[0];
      LW, SW:      is_misaligned = |lo;
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane logic for the load/store unit: byte enables, store replication, load extract/extend.
// Misaligned half/word addresses are naturally truncated because only the relevant address bits are used.
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_op,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_rdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  load_store_func_code st_op_s;
  load_store_func_code ld_op_s;
  logic [7:0]          ld_byte_s;
  logic [15:0]         ld_half_s;

  assign st_op_s   = load_store_func_code'(st_op);
  assign ld_op_s   = load_store_func_code'(ld_op);
  assign ld_byte_s = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half_s = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];

  // Byte enables and lane-replicated write data for the request phase
  always_comb begin
    be      = BE_WORD;
    st_data = 32'h0000_0000;
    case (st_op_s)
      SB: begin
        be      = BE_BYTE << st_addr_lo;
        st_data = {4{st_wdata[7:0]}};
      end
      SH: begin
        be      = BE_HALF << {st_addr_lo[1], 1'b0};
        st_data = {2{st_wdata[15:0]}};
      end
      SW: begin
        be      = BE_WORD;
        st_data = st_wdata;
      end
      default: begin
        be      = BE_WORD;
        st_data = 32'h0000_0000;
      end
    endcase
  end

  // Load data extraction with sign or zero extension
  always_comb begin
    ld_data = ld_rdata;
    case (ld_op_s)
      LB:      ld_data = {{24{ld_byte_s[7]}}, ld_byte_s};
      LBU:     ld_data = {24'h00_0000, ld_byte_s};
      LH:      ld_data = {{16{ld_half_s[15]}}, ld_half_s};
      LHU:     ld_data = {16'h0000, ld_half_s};
      LW:      ld_data = ld_rdata;
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding req/gnt/rvalid data-memory master with load writeback.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en_lsu_ip,
  input  logic [2:0]            lsu_operator_ip,
  input  logic [ADDR_WIDTH-1:0] addr_ip,
  input  logic                  addr_valid_ip,
  input  logic [DATA_WIDTH-1:0] wdata_ip,
  output logic                  lsu_busy_op,
  output logic [DATA_WIDTH-1:0] mem_data_op,
  output logic                  mem_data_valid_op,
  output logic                  store_done_op,
  output logic                  lsu_err_op,
  output logic                  data_req_op,
  output logic                  data_we_op,
  output logic [3:0]            data_be_op,
  output logic [ADDR_WIDTH-1:0] data_addr_op,
  output logic [DATA_WIDTH-1:0] data_wdata_op,
  input  logic                  data_gnt_ip,
  input  logic                  data_rvalid_ip,
  input  logic [DATA_WIDTH-1:0] data_rdata_ip
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e          state_r;
  load_store_func_code op_r;
  logic [1:0]          addr_lo_r;
  logic [CNT_W-1:0]    wait_cnt_r;

  load_store_func_code op_s;
  logic                accept_s;
  logic                trap_s;
  logic [3:0]          be_s;
  logic [31:0]         st_data_s;
  logic [31:0]         ld_data_s;

  assign op_s     = load_store_func_code'(lsu_operator_ip);
  assign accept_s = en_lsu_ip && addr_valid_ip;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s = is_misaligned(op_s, addr_ip[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  load_store_unit_align u_align (
    .st_op      (lsu_operator_ip),
    .st_addr_lo (addr_ip[1:0]),
    .st_wdata   (wdata_ip),
    .ld_op      (op_r),
    .ld_addr_lo (addr_lo_r),
    .ld_rdata   (data_rdata_ip),
    .be         (be_s),
    .st_data    (st_data_s),
    .ld_data    (ld_data_s)
  );

  // Transaction FSM with registered memory-port and writeback outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r           <= LSU_IDLE;
      op_r              <= LB;
      addr_lo_r         <= 2'b00;
      wait_cnt_r        <= '0;
      lsu_busy_op       <= 1'b0;
      mem_data_op       <= '0;
      mem_data_valid_op <= 1'b0;
      store_done_op     <= 1'b0;
      lsu_err_op        <= 1'b0;
      data_req_op       <= 1'b0;
      data_we_op        <= 1'b0;
      data_be_op        <= 4'b0000;
      data_addr_op      <= '0;
      data_wdata_op     <= '0;
    end else begin
      mem_data_valid_op <= 1'b0;
      store_done_op     <= 1'b0;
      lsu_err_op        <= 1'b0;
      case (state_r)
        LSU_IDLE, LSU_RESP: begin
          if (accept_s) begin
            op_r       <= op_s;
            addr_lo_r  <= addr_ip[1:0];
            wait_cnt_r <= '0;
            if (trap_s) begin
              state_r     <= LSU_RESP;
              lsu_err_op  <= 1'b1;
              lsu_busy_op <= 1'b0;
            end else begin
              state_r       <= LSU_REQ;
              lsu_busy_op   <= 1'b1;
              data_req_op   <= 1'b1;
              data_we_op    <= is_store(op_s);
              data_be_op    <= be_s;
              data_addr_op  <= {addr_ip[ADDR_WIDTH-1:2], 2'b00};
              data_wdata_op <= st_data_s;
            end
          end else begin
            state_r     <= LSU_IDLE;
            lsu_busy_op <= 1'b0;
          end
        end
        LSU_REQ: begin
          if (data_gnt_ip) begin
            data_req_op <= 1'b0;
            if (data_rvalid_ip) begin
              state_r     <= LSU_RESP;
              lsu_busy_op <= 1'b0;
              if (is_store(op_r)) begin
                store_done_op <= 1'b1;
              end else begin
                mem_data_op       <= ld_data_s;
                mem_data_valid_op <= 1'b1;
              end
            end else begin
              state_r     <= LSU_WAIT;
              lsu_busy_op <= 1'b1;
            end
          end else begin
            state_r     <= LSU_REQ;
            lsu_busy_op <= 1'b1;
          end
        end
        LSU_WAIT: begin
          if (data_rvalid_ip) begin
            state_r     <= LSU_RESP;
            lsu_busy_op <= 1'b0;
            if (is_store(op_r)) begin
              store_done_op <= 1'b1;
            end else begin
              mem_data_op       <= ld_data_s;
              mem_data_valid_op <= 1'b1;
            end
          end else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // No response in time: abandon the access, report only the error
            state_r     <= LSU_IDLE;
            lsu_busy_op <= 1'b0;
            lsu_err_op  <= 1'b1;
          end else begin
            state_r     <= LSU_WAIT;
            lsu_busy_op <= 1'b1;
            wait_cnt_r  <= wait_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r     <= LSU_IDLE;
          lsu_busy_op <= 1'b0;
          data_req_op <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand sequences and random transactions.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int T = 255;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en_lsu_ip = 1'b0;
  logic [2:0]  lsu_operator_ip = 3'd0;
  logic [31:0] addr_ip = 32'h0;
  logic        addr_valid_ip = 1'b0;
  logic [31:0] wdata_ip = 32'h0;
  logic        lsu_busy_op, mem_data_valid_op, store_done_op, lsu_err_op;
  logic [31:0] mem_data_op;
  logic        data_req_op, data_we_op;
  logic [3:0]  data_be_op;
  logic [31:0] data_addr_op, data_wdata_op;
  logic        data_gnt_ip = 1'b0;
  logic        data_rvalid_ip = 1'b0;
  logic [31:0] data_rdata_ip = 32'h0;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .en_lsu_ip(en_lsu_ip), .lsu_operator_ip(lsu_operator_ip),
    .addr_ip(addr_ip), .addr_valid_ip(addr_valid_ip), .wdata_ip(wdata_ip),
    .lsu_busy_op(lsu_busy_op), .mem_data_op(mem_data_op), .mem_data_valid_op(mem_data_valid_op),
    .store_done_op(store_done_op), .lsu_err_op(lsu_err_op), .data_req_op(data_req_op),
    .data_we_op(data_we_op), .data_be_op(data_be_op), .data_addr_op(data_addr_op),
    .data_wdata_op(data_wdata_op), .data_gnt_ip(data_gnt_ip), .data_rvalid_ip(data_rvalid_ip),
    .data_rdata_ip(data_rdata_ip)
  );

  always #5 clock = ~clock;

  typedef struct {
    load_store_func_code op;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;
    logic [31:0] wd, data;
    bit          misal;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference behaviour from plain arithmetic on the lane rules
  function automatic void model(input load_store_func_code op, input logic [31:0] a, w, r,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] ld, output bit mis);
    int unsigned lo = a % 4;
    int unsigned hlo = lo - (lo % 2);
    be = 4'hF; wd = 32'h0; ld = 32'h0; mis = 1'b0;
    case (op)
      LB, LBU: begin
        ld = (r >> (8 * lo)) & 32'hFF;
        if (op == LB && ld >= 32'd128) ld = ld - 32'd256;
      end
      LH, LHU: begin
        ld = (r >> (8 * hlo)) & 32'hFFFF;
        if (op == LH && ld >= 32'd32768) ld = ld - 32'd65536;
        mis = (lo % 2) != 0;
      end
      LW: begin ld = r; mis = lo != 0; end
      SB: begin be = 4'(1 << lo); wd = (w & 32'hFF) * 32'h0101_0101; end
      SH: begin be = 4'(3 << hlo); wd = (w & 32'hFFFF) * 32'h0001_0001; mis = (lo % 2) != 0; end
      default: begin wd = w; mis = lo != 0; end
    endcase
  endfunction

  task automatic run_txn(input load_store_func_code op, input logic [31:0] a, w, r,
                         input int gnt_dly, input int rv_dly, input bit trap,
                         input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] edata,
                         input string tag);
    bit st = (op == SB || op == SH || op == SW);
    en_lsu_ip = 1'b1; lsu_operator_ip = op; addr_ip = a; addr_valid_ip = 1'b1; wdata_ip = w;
    cyc();
    en_lsu_ip = 1'b0; addr_valid_ip = 1'b0;
    if (trap) begin
      chk({tag, " trap_req"}, data_req_op, 32'd0);
      chk({tag, " trap_err"}, lsu_err_op, 32'd1);
      chk({tag, " trap_busy"}, lsu_busy_op, 32'd0);
      cyc();
      chk({tag, " trap_err_clr"}, lsu_err_op, 32'd0);
      chk({tag, " trap_no_data"}, {mem_data_valid_op, store_done_op}, 32'd0);
      return;
    end
    for (int g = 0; g <= gnt_dly; g++) begin
      chk({tag, " req"}, data_req_op, 32'd1);
      chk({tag, " addr"}, data_addr_op, {a[31:2], 2'b00});
      chk({tag, " we"}, data_we_op, {31'd0, st});
      chk({tag, " be"}, data_be_op, {28'd0, ebe});
      if (st) chk({tag, " wdata"}, data_wdata_op, ewd);
      chk({tag, " busy"}, lsu_busy_op, 32'd1);
      data_gnt_ip = (g == gnt_dly);
      data_rvalid_ip = (g == gnt_dly) && (rv_dly < 0);
      data_rdata_ip = r;
      // Competing request while busy must be ignored
      en_lsu_ip = (g != gnt_dly); addr_valid_ip = en_lsu_ip;
      lsu_operator_ip = SW; addr_ip = $urandom; wdata_ip = $urandom;
      cyc();
    end
    data_gnt_ip = 1'b0; en_lsu_ip = 1'b0; addr_valid_ip = 1'b0;
    for (int k = 0; k <= rv_dly; k++) begin
      chk({tag, " wait_req"}, data_req_op, 32'd0);
      chk({tag, " wait_busy"}, lsu_busy_op, 32'd1);
      data_rvalid_ip = (k == rv_dly);
      cyc();
    end
    data_rvalid_ip = 1'b0;
    chk({tag, " valid"}, mem_data_valid_op, {31'd0, !st});
    chk({tag, " done"}, store_done_op, {31'd0, st});
    chk({tag, " err"}, lsu_err_op, 32'd0);
    chk({tag, " busy_end"}, lsu_busy_op, 32'd0);
    if (!st) chk({tag, " data"}, mem_data_op, edata);
    cyc();
    chk({tag, " pulse_clr"}, {mem_data_valid_op, store_done_op, data_req_op}, 32'd0);
  endtask

  initial begin
    int k;
    tbl[0] = '{SW,  32'h100, 32'hDEADBEEF, 32'h0,        4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1] = '{SB,  32'h103, 32'h000000A5, 32'h0,        4'h8, 32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[2] = '{LB,  32'h102, 32'h0,        32'h0080FF00, 4'hF, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[3] = '{LBU, 32'h102, 32'h0,        32'h0080FF00, 4'hF, 32'h0,        32'h00000080, 1'b0};
    tbl[4] = '{LH,  32'h102, 32'h0,        32'h0080FF00, 4'hF, 32'h0,        32'h00000080, 1'b0};
    tbl[5] = '{LH,  32'h100, 32'h0,        32'h0080FF00, 4'hF, 32'h0,        32'hFFFFFF00, 1'b0};
    tbl[6] = '{LHU, 32'h100, 32'h0,        32'h0080FF00, 4'hF, 32'h0,        32'h0000FF00, 1'b0};
    tbl[7] = '{SH,  32'h102, 32'h1234ABCD, 32'h0,        4'hC, 32'hABCDABCD, 32'h0,        1'b0};
    tbl[8] = '{LW,  32'h101, 32'h0,        32'hCAFEF00D, 4'hF, 32'h0,        32'hCAFEF00D, 1'b1};
    tbl[9] = '{SH,  32'h101, 32'h00005A5A, 32'h0,        4'h3, 32'h5A5A5A5A, 32'h0,        1'b1};

    // Reset state
    repeat (3) cyc();
    chk("rst_outs", {lsu_busy_op, mem_data_valid_op, store_done_op, lsu_err_op, data_req_op, data_we_op, data_be_op}, 32'd0);
    chk("rst_addr", data_addr_op, 32'd0);
    chk("rst_wdata", data_wdata_op, 32'd0);
    chk("rst_mdata", mem_data_op, 32'd0);
    reset = 1'b1;
    cyc();

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, i % 3, (i % 4) - 1,
              tbl[i].misal && TRAP_EN, tbl[i].be, tbl[i].wd, tbl[i].data, $sformatf("vec%0d", i));

    // Grant held off for five cycles
    run_txn(LW, 32'h400, 32'h0, 32'h13579BDF, 5, 1, 1'b0, 4'hF, 32'h0, 32'h13579BDF, "gnt_stall");

    // Timeout: granted load never answered
    en_lsu_ip = 1'b1; lsu_operator_ip = LW; addr_ip = 32'h200; addr_valid_ip = 1'b1;
    cyc();
    en_lsu_ip = 1'b0; addr_valid_ip = 1'b0; data_gnt_ip = 1'b1;
    cyc();
    data_gnt_ip = 1'b0;
    k = 0;
    for (int n = 1; n <= T + 5; n++) begin
      cyc();
      if (lsu_err_op) begin k = n; break; end
      if (n == T - 1) chk("to_busy", lsu_busy_op, 32'd1);
    end
    chk("to_cycle", k, T);
    chk("to_idle", {lsu_busy_op, data_req_op, mem_data_valid_op, store_done_op}, 32'd0);
    data_rvalid_ip = 1'b1; data_rdata_ip = 32'h55AA55AA;
    cyc();
    data_rvalid_ip = 1'b0;
    chk("late_rvalid", {mem_data_valid_op, store_done_op, lsu_err_op, lsu_busy_op}, 32'd0);

    // Reset asserted while waiting for the response
    en_lsu_ip = 1'b1; lsu_operator_ip = SW; addr_ip = 32'h300; addr_valid_ip = 1'b1; wdata_ip = 32'h11223344;
    cyc();
    en_lsu_ip = 1'b0; addr_valid_ip = 1'b0; data_gnt_ip = 1'b1;
    cyc();
    data_gnt_ip = 1'b0;
    reset = 1'b0;
    cyc();
    chk("mid_rst_ctrl", {lsu_busy_op, mem_data_valid_op, store_done_op, lsu_err_op, data_req_op, data_we_op, data_be_op}, 32'd0);
    chk("mid_rst_addr", data_addr_op, 32'd0);
    chk("mid_rst_wdata", data_wdata_op, 32'd0);
    reset = 1'b1; data_rvalid_ip = 1'b1;
    cyc();
    data_rvalid_ip = 1'b0;
    chk("post_rst_a", {mem_data_valid_op, store_done_op, lsu_err_op, lsu_busy_op}, 32'd0);
    cyc();
    chk("post_rst_b", {mem_data_valid_op, store_done_op, lsu_err_op, lsu_busy_op}, 32'd0);

    // Random transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      load_store_func_code op;
      logic [31:0] a, w, r, wd, ld;
      logic [3:0] be;
      bit mis;
      op = load_store_func_code'(3'($urandom_range(0, 7)));
      a = $urandom; w = $urandom; r = $urandom;
      model(op, a, w, r, be, wd, ld, mis);
      run_txn(op, a, w, r, $urandom_range(0, 3), int'($urandom_range(0, 4)) - 1,
              mis && TRAP_EN, be, wd, ld, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
